msk_pipe_reg: RTL and testbench
===============================

Name: msk_pipe_reg

Overview:
- Parametrised masked pipeline register: carries `count` d-share masked bits through DEPTH elastic stages with a valid/ready handshake, synchronous flush and optional share refresh at ingress.
- Successor of the plain one-stage masked register.
- Used between masked gadgets (S-box layers, key schedule) where backpressure and stalls are needed without breaking share separation.

Parameters:
- d, `DEFAULTSHARES (2), number of shares per masked bit, >=2
- count, 1, number of masked bits per word
- DEPTH, 1, number of register stages, >=1
- REFRESH, 0, 1 = re-randomise shares on capture into stage 0 using rnd_in

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of all stage valids
- in_data  in  count*d  masked input, share-major layout identical to existing masked buses
- in_valid  in  1  input word valid
- in_ready  out  1  stage 0 can accept
- rnd_in  in  count*(d-1)  fresh randomness, sampled only on accept when REFRESH=1; ignored otherwise
- out_data  out  count*d  data of stage DEPTH-1
- out_valid  out  1  stage DEPTH-1 holds a word
- out_ready  in  1  consumer accepts

Behaviour:
- Reset (rst_n=0 at clk edge): all stage valids=0, all stage data=0.
  - out_valid=0, out_data=0.
  - in_ready=0 while rst_n=0.
  - Reset mid-transfer drops all in-flight words; no partial word survives.
- Stage i holds data_i and v_i. Per-stage ready r_i = !v_i | r_{i+1}, with r_DEPTH = out_ready. in_ready = r_0 & rst_n & !flush.
- Transfers:
  - Stage i loads from stage i-1 (stage 0 loads from input) when r_i=1.
  - v_i <= v_{i-1} on that edge; data_i loads only if v_{i-1}=1, otherwise it holds its old value, so bubbles do not toggle data registers.
- Throughput 1 word/cycle with out_ready held 1.
- Latency: input accepted at edge t appears on out_valid/out_data after edge t+DEPTH-1, i.e. visible in cycle t+DEPTH.
- Stall: out_ready=0 with the pipeline full gives in_ready=0. All data is held bit-exact and no valid is lost or duplicated.
- Bubble collapse: an empty stage accepts even when downstream is stalled.
- Flush=1 at an edge:
  - All v_i <= 0 and the input is not accepted.
  - Data registers hold (not zeroed).
  - Flush has priority over simultaneous accept and output transfer.
  - out_valid=0 from the next cycle.
- REFRESH=1, per masked bit j on accept:
  - share k (k<d-1) = in share k XOR rnd_in[j*(d-1)+k]
  - share d-1 = in share d-1 XOR (XOR of the d-1 rnd bits of j)
  - The unmasked value (XOR of all shares) must equal the input's.
- REFRESH=0: stage 0 stores in_data verbatim.
- Security rule: each share lives in its own flop. No logic combines shares except the refresh XORs, and each of those involves exactly one share plus randomness. No combinational path from in_data to out_data.
- Unmasked value at output equals unmasked value at input for every word, in order.

Decomposition:
- Shared package: share-indexing helper (bit j, share k -> bus index) and the DEFAULTSHARES default, reused by all masked modules.
- One sub-module, msk_pipe_stage: one stage (data reg, valid flop, ready logic), instantiated DEPTH times via generate.
- Refresh logic is a generate block at stage 0.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=0. After release, in_ready=1 with an empty pipe.
- Streaming, d=2, count=1, DEPTH=3, out_ready=1, words 2'b01, 2'b10, 2'b11 on consecutive edges -> same words on out_data in cycles 3, 4, 5 with out_valid=1.
- Backpressure:
  - Fill the DEPTH=3 pipe, hold out_ready=0 for 5 cycles -> in_ready=0 and out_data stable.
  - Raise out_ready -> 3 words emitted in order, no duplicates.
- Flush: 2 words in flight, assert flush with in_valid=1 -> next cycle out_valid=0 and that input is not accepted. Afterwards the pipe accepts normally.
- Refresh: REFRESH=1, d=3, count=2, in_data shares (1,0,0)/(0,1,1), rnd_in=4'b1011 -> stored shares differ from the input and each bit's share XOR equals 1 and 0 respectively. With REFRESH=0 the stored word is unchanged.
- Bubbles: random in_valid/out_ready for 1000 cycles against a scoreboard -> in-order, lossless unmasked values; no data toggle when v_{i-1}=0.

Source files
------------

// File: rtl/msk_pipe_reg_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// msk_pipe_reg_pkg : share indexing helper and default share count. rev 1.0
// ------------------------------------------------------------------------
package msk_pipe_reg_pkg;

  localparam int DEFAULTSHARES = 2;

  // Share-major bus layout: all bits of share 0 first, then share 1, ...
  function automatic int share_idx(input int bit_j, input int share_k, input int n_bits);
    return share_k * n_bits + bit_j;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msk_pipe_reg_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// msk_pipe_reg_if : masked valid/ready bus with flush and refresh rnd. rev 1.0
// ------------------------------------------------------------------------
interface msk_pipe_reg_if
  import msk_pipe_reg_pkg::*;
#(
  parameter int d     = DEFAULTSHARES,
  parameter int count = 1
);

  logic                     flush;
  logic [count*d-1:0]       in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [count*(d-1)-1:0]   rnd_in;
  logic [count*d-1:0]       out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport slave (
    input  flush, in_data, in_valid, rnd_in, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output flush, in_data, in_valid, rnd_in, out_ready,
    input  in_ready, out_data, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/msk_pipe_stage.sv
`default_nettype none
// ------------------------------------------------------------------------
// msk_pipe_stage : one elastic stage (data reg, valid flop, ready). rev 1.0
// ------------------------------------------------------------------------
module msk_pipe_stage #(
  parameter int WIDTH = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             flush,
  input  wire logic             up_valid,
  input  wire logic [WIDTH-1:0] up_data,
  input  wire logic             down_ready,
  output logic                  valid,
  output logic [WIDTH-1:0]      data
);

  logic w_ready;

  assign w_ready = ~valid | down_ready;

  // Data only loads behind a real word so bubbles never toggle share flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (w_ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/msk_pipe_reg.sv
`default_nettype none
// ------------------------------------------------------------------------
// msk_pipe_reg : DEPTH-stage elastic masked register, optional refresh. rev 1.0
// ------------------------------------------------------------------------
module msk_pipe_reg
  import msk_pipe_reg_pkg::*;
#(
  parameter int d       = DEFAULTSHARES,
  parameter int count   = 1,
  parameter int DEPTH   = 1,
  parameter int REFRESH = 0
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  msk_pipe_reg_if.slave  bus
);

  localparam int W = count * d;

  logic [W-1:0]     w_stage_in;
  logic [W-1:0]     w_data [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_down;

  // Each refresh XOR touches exactly one share and randomness only.
  if (REFRESH != 0) begin : g_refresh
    for (genvar j = 0; j < count; j++) begin : g_bit
      for (genvar k = 0; k < d - 1; k++) begin : g_share
        assign w_stage_in[share_idx(j, k, count)] =
          bus.in_data[share_idx(j, k, count)] ^ bus.rnd_in[j*(d-1)+k];
      end
      assign w_stage_in[share_idx(j, d-1, count)] =
        bus.in_data[share_idx(j, d-1, count)] ^ (^bus.rnd_in[j*(d-1) +: (d-1)]);
    end
  end else begin : g_verbatim
    logic w_unused_rnd;
    assign w_stage_in   = bus.in_data;
    assign w_unused_rnd = ^bus.rnd_in;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic         w_up_valid;
    logic [W-1:0] w_up_data;

    if (i == 0) begin : g_head
      assign w_up_valid = bus.in_valid;
      assign w_up_data  = w_stage_in;
    end else begin : g_body
      assign w_up_valid = w_valid[i-1];
      assign w_up_data  = w_data[i-1];
    end

    // Ready of the next stage, expanded over downstream valids to avoid a ripple loop.
    if (i == DEPTH - 1) begin : g_tail
      assign w_down[i] = bus.out_ready;
    end else begin : g_inner
      assign w_down[i] = bus.out_ready | ~(&w_valid[DEPTH-1:i+1]);
    end

    msk_pipe_stage #(
      .WIDTH (W)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (bus.flush),
      .up_valid   (w_up_valid),
      .up_data    (w_up_data),
      .down_ready (w_down[i]),
      .valid      (w_valid[i]),
      .data       (w_data[i])
    );
  end

  assign bus.in_ready  = (~w_valid[0] | w_down[0]) & rst_n & ~bus.flush;
  assign bus.out_valid = w_valid[DEPTH-1];
  assign bus.out_data  = w_data[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_msk_pipe_reg.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_msk_pipe_reg : three configurations against a queue-based model. rev 1.0
// ------------------------------------------------------------------------
module tb_msk_pipe_reg;

  logic clk;
  logic rst_n;

  // Instance 0: d=2,count=1,DEPTH=3 ; 1: d=3,count=2,DEPTH=2,REFRESH ; 2: d=3,count=2,DEPTH=1
  logic       iv   [3];
  logic       fl   [3];
  logic       ordy [3];
  logic [5:0] idat [3];
  logic [3:0] rnd  [3];
  logic [5:0] odat [3];
  logic       ov   [3];
  logic       irdy [3];

  int n_vec = 0;
  int n_err = 0;

  msk_pipe_reg_if #(.d(2), .count(1)) bus_a ();
  msk_pipe_reg_if #(.d(3), .count(2)) bus_b ();
  msk_pipe_reg_if #(.d(3), .count(2)) bus_c ();

  msk_pipe_reg #(.d(2), .count(1), .DEPTH(3), .REFRESH(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  msk_pipe_reg #(.d(3), .count(2), .DEPTH(2), .REFRESH(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  msk_pipe_reg #(.d(3), .count(2), .DEPTH(1), .REFRESH(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  assign bus_a.flush = fl[0];   assign bus_a.in_valid = iv[0];  assign bus_a.out_ready = ordy[0];
  assign bus_a.in_data = idat[0][1:0];  assign bus_a.rnd_in = rnd[0][0];
  assign odat[0] = {4'b0, bus_a.out_data};  assign ov[0] = bus_a.out_valid;  assign irdy[0] = bus_a.in_ready;

  assign bus_b.flush = fl[1];   assign bus_b.in_valid = iv[1];  assign bus_b.out_ready = ordy[1];
  assign bus_b.in_data = idat[1];  assign bus_b.rnd_in = rnd[1];
  assign odat[1] = bus_b.out_data;  assign ov[1] = bus_b.out_valid;  assign irdy[1] = bus_b.in_ready;

  assign bus_c.flush = fl[2];   assign bus_c.in_valid = iv[2];  assign bus_c.out_ready = ordy[2];
  assign bus_c.in_data = idat[2];  assign bus_c.rnd_in = rnd[2];
  assign odat[2] = bus_c.out_data;  assign ov[2] = bus_c.out_valid;  assign irdy[2] = bus_c.in_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep(input int n);
    return (n == 0) ? 3 : ((n == 1) ? 2 : 1);
  endfunction

  function automatic logic [5:0] wmask(input int n);
    return (n == 0) ? 6'h03 : 6'h3f;
  endfunction

  function automatic logic [5:0] refresh_word(input logic [5:0] w, input logic [3:0] r,
                                              input int dd, input int cc);
    logic [5:0] o;
    logic       acc;
    o = w;
    for (int j = 0; j < cc; j++) begin
      acc = 1'b0;
      for (int k = 0; k < dd - 1; k++) begin
        o[k*cc+j] = w[k*cc+j] ^ r[j*(dd-1)+k];
        acc       = acc ^ r[j*(dd-1)+k];
      end
      o[(dd-1)*cc+j] = w[(dd-1)*cc+j] ^ acc;
    end
    return o;
  endfunction

  function automatic logic [1:0] unmask(input logic [5:0] w, input int dd, input int cc);
    logic [1:0] u;
    u = 2'b00;
    for (int j = 0; j < cc; j++)
      for (int k = 0; k < dd; k++)
        u[j] = u[j] ^ w[k*cc+j];
    return u;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: in-flight words in order with acceptance edge; the oldest word always
  // advances, so it shows at the output DEPTH-1 edges after acceptance.
  logic [5:0] qw [3][8];
  int         qt [3][8];
  int         qh [3];
  int         qn [3];
  logic [5:0] last_out [3];
  logic       pacc  [3];
  logic       pfire [3];
  logic [5:0] pword [3];
  int         cyc = 0;

  initial begin
    logic exp_ir;
    logic exp_ov;
    for (int n = 0; n < 3; n++) begin
      qh[n] = 0; qn[n] = 0; last_out[n] = '0; pacc[n] = 1'b0; pfire[n] = 1'b0; pword[n] = '0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int n = 0; n < 3; n++) begin
        if (!rst_n) begin
          qn[n] = 0;
          last_out[n] = '0;
        end else if (fl[n]) begin
          qn[n] = 0;
        end else begin
          if (pfire[n]) begin
            qh[n] = (qh[n] + 1) % 8;
            qn[n] = qn[n] - 1;
          end
          if (pacc[n]) begin
            qw[n][(qh[n] + qn[n]) % 8] = pword[n];
            qt[n][(qh[n] + qn[n]) % 8] = cyc;
            qn[n] = qn[n] + 1;
          end
        end
      end
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
        exp_ir = rst_n && !fl[n] && (ordy[n] || qn[n] < dep(n));
        exp_ov = (qn[n] > 0) && ((cyc - qt[n][qh[n]]) >= dep(n) - 1);
        chk($sformatf("m%0d_in_ready", n), {31'b0, irdy[n]}, {31'b0, exp_ir});
        chk($sformatf("m%0d_out_valid", n), {31'b0, ov[n]}, {31'b0, exp_ov});
        if (exp_ov) begin
          chk($sformatf("m%0d_out_data", n), {26'b0, odat[n]}, {26'b0, qw[n][qh[n]]});
          last_out[n] = qw[n][qh[n]];
        end else begin
          chk($sformatf("m%0d_hold_data", n), {26'b0, odat[n]}, {26'b0, last_out[n]});
        end
        pfire[n] = exp_ov && ordy[n];
        pacc[n]  = iv[n] && exp_ir;
        pword[n] = (n == 1) ? refresh_word(idat[1], rnd[1], 3, 2) : (idat[n] & wmask(n));
      end
    end
  end

  initial begin
    logic [1:0] bp_w [3];
    bp_w[0] = 2'd2; bp_w[1] = 2'd1; bp_w[2] = 2'd3;
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) begin
      iv[n] = 1'b1; fl[n] = 1'b0; ordy[n] = 1'b1; idat[n] = 6'h2a; rnd[n] = 4'h0;
    end

    // Reset with input valid held high
    for (int c = 0; c < 2; c++) begin
      step();
      @(negedge clk);
      chk("rst_out_valid", {31'b0, ov[0]}, 32'd0);
      chk("rst_out_data", {26'b0, odat[0]}, 32'd0);
      chk("rst_in_ready", {31'b0, irdy[0]}, 32'd0);
    end
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) iv[n] = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", {31'b0, irdy[0]}, 32'd1);

    // Streaming: 01,10,11 on consecutive edges
    step(); iv[0] = 1'b1; idat[0] = 6'd1;
    step(); idat[0] = 6'd2;
    step(); idat[0] = 6'd3;
    step(); iv[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      @(negedge clk);
      chk("stream_valid", {31'b0, ov[0]}, 32'd1);
      chk("stream_data", {26'b0, odat[0]}, i + 1);
    end
    step();
    @(negedge clk);
    chk("stream_drained", {31'b0, ov[0]}, 32'd0);

    // Backpressure: fill, stall 5 cycles, release
    step(); ordy[0] = 1'b0; iv[0] = 1'b1; idat[0] = 6'd2;
    step(); idat[0] = 6'd1;
    step(); idat[0] = 6'd3;
    step(); idat[0] = 6'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'b0, irdy[0]}, 32'd0);
      chk("stall_valid", {31'b0, ov[0]}, 32'd1);
      chk("stall_data", {26'b0, odat[0]}, 32'd2);
      step();
    end
    ordy[0] = 1'b1; iv[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, ov[0]}, 32'd1);
      chk("bp_data", {30'b0, odat[0][1:0]}, {30'b0, bp_w[i]});
      step();
    end
    @(negedge clk);
    chk("bp_no_dup", {31'b0, ov[0]}, 32'd0);

    // Flush with two words in flight and input valid
    step(); iv[0] = 1'b1; idat[0] = 6'd1;
    step(); idat[0] = 6'd2;
    step(); fl[0] = 1'b1; idat[0] = 6'd3;
    @(negedge clk);
    chk("flush_in_ready", {31'b0, irdy[0]}, 32'd0);
    step(); fl[0] = 1'b0; iv[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("flush_valid", {31'b0, ov[0]}, 32'd0);
      step();
    end
    iv[0] = 1'b1; idat[0] = 6'd3;
    step(); iv[0] = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("post_flush_valid", {31'b0, ov[0]}, 32'd1);
    chk("post_flush_data", {26'b0, odat[0]}, 32'd3);

    // Refresh vs verbatim: shares (1,0,0)/(0,1,1), rnd 1011
    step();
    ordy[1] = 1'b0; ordy[2] = 1'b0; iv[1] = 1'b1; iv[2] = 1'b1;
    idat[1] = 6'b101001; idat[2] = 6'b101001; rnd[1] = 4'b1011; rnd[2] = 4'b1011;
    step(); iv[1] = 1'b0; iv[2] = 1'b0;
    step();
    @(negedge clk);
    chk("norf_word", {26'b0, odat[2]}, 32'b101001);
    chk("rf_word", {26'b0, odat[1]}, 32'b000100);
    chk("rf_differs", {31'b0, (odat[1] != 6'b101001)}, 32'd1);
    chk("rf_unmask", {30'b0, unmask(odat[1], 3, 2)}, 32'b01);
    chk("rf_model_pin", {26'b0, refresh_word(6'b101001, 4'b1011, 3, 2)}, {26'b0, odat[1]});
    step(); ordy[1] = 1'b1; ordy[2] = 1'b1;

    // Randomised traffic with rare flush and reset
    for (int c = 0; c < 1000; c++) begin
      step();
      rst_n = ($urandom_range(0, 299) != 0);
      for (int n = 0; n < 3; n++) begin
        iv[n]   = $urandom_range(0, 1) == 1;
        ordy[n] = $urandom_range(0, 3) != 0;
        fl[n]   = $urandom_range(0, 39) == 0;
        idat[n] = 6'($urandom);
        rnd[n]  = 4'($urandom);
      end
    end
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      iv[n] = 1'b0; fl[n] = 1'b0; ordy[n] = 1'b1;
    end
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
